stage2_mem_ctrl: RTL
====================

// Module: stage2_mem_ctrl
// PURPOSE
//  Stage-2 memory/stack sequencer. Sits directly downstream of the stage-1/2 pipeline register.
//  Consumes load/store/push/pop/reti flags plus A/B/immediate, and runs req/ack data-memory transactions.
//  Owns the stack pointer and stalls the stage-1/2 register enable while a transaction is outstanding.
// PARAMETERS
//  ADDR_W   16      data-memory address width; SP width
//  SP_INIT  16'h0   stack pointer value after reset (full-descending stack)
// PORTS
//  clk            in   1       single clock, all state on posedge
//  rst            in   1       asynchronous, active-low reset
//  valid_i        in   1       stage-2 holds a live instruction
//  load_i         in   1       load: mem[EA] -> rdata_o
//  store_i        in   1       store: data_i -> mem[EA]
//  push_i         in   1       push data_i onto stack
//  pop_i          in   1       pop stack top -> rdata_o
//  reti_i         in   1       two-word pop: return address, then status
//  addr_base_i    in   24      A operand (address base)
//  data_i         in   24      B operand (store/push data)
//  imm_i          in   9       signed address offset
//  stall_o        out  1       high = hold stage-1/2 register (enable low)
//  mem_req_o      out  1       memory request, held until mem_ack_i
//  mem_we_o       out  1       1 = write, 0 = read
//  mem_addr_o     out  ADDR_W  memory address
//  mem_wdata_o    out  24      write data
//  mem_ack_i      in   1       memory completes current beat this cycle
//  mem_rdata_i    in   24      read data, valid with mem_ack_i on reads
//  rdata_o        out  24      last load/pop result, held until next load/pop
//  rdata_valid_o  out  1       1-cycle pulse: rdata_o updated
//  ret_addr_o     out  24      reti beat-1 data
//  ret_status_o   out  24      reti beat-2 data
//  ret_valid_o    out  1       1-cycle pulse: reti complete
//  sp_o           out  ADDR_W  current stack pointer
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE; sp_o=SP_INIT; all other outputs 0.
//   An in-flight request is abandoned: mem_req_o drops immediately.
//  memop = load_i|store_i|push_i|pop_i|reti_i.
//   Priority when several flags are set: reti > pop > push > load > store. Only the winner executes.
//  EA = (addr_base_i + sign_ext(imm_i)) truncated to low ADDR_W bits.
//  SP arithmetic is modulo 2^ADDR_W; wraps without error.
//  FSM states: IDLE, ACCESS, RETI2, DONE.
//   IDLE:   if valid_i&memop, latch op/addr/data and register mem_req_o=1 -> ACCESS.
//           Addr/we: push = SP-1, we=1; pop/reti = SP, we=0; load = EA, we=0; store = EA, we=1.
//   ACCESS: hold req/we/addr/wdata stable until mem_ack_i.
//           On ack, update per op:
//            push: sp<=SP-1.
//            pop: sp<=SP+1, capture rdata.
//            load: capture rdata.
//            reti: sp<=SP+1, capture ret_addr_o, re-issue req at SP+1 -> RETI2.
//           Non-reti ops: req<=0 -> DONE.
//   RETI2:  on ack: sp<=SP+1, capture ret_status_o, req<=0 -> DONE.
//   DONE:   one cycle, unconditional -> IDLE. rdata_valid_o (load/pop) or ret_valid_o (reti) high here.
//           No new op is accepted in DONE.
//  stall_o = (IDLE & valid_i & memop) | ACCESS | RETI2. Combinational; low in DONE so upstream advances once.
//  Latency: accept cycle + N ack-wait cycles (N>=1) + DONE. Minimum 3 cycles per single-beat op.
//   Minimum for reti is 4 cycles.
//  mem_ack_i while mem_req_o=0 is ignored.
//  mem_rdata_i is sampled only on ack of a read beat.
//  valid_i=0 or memop=0 in IDLE: no activity, stall_o=0.
// TESTING
//  SP_INIT=0, push data_i=24'hABCDEF, ack after 2 cycles
//   -> write addr 16'hFFFF, wdata ABCDEF; sp_o=FFFF; stall high 3 cycles.
//  Then pop, ack after 3 cycles
//   -> read addr FFFF, rdata_o=ABCDEF, rdata_valid_o 1-cycle pulse; sp_o=0000.
//  load addr_base_i=24'h000100, imm_i=9'h1FF
//   -> mem_addr_o=16'h00FF, we=0; rdata_o updated on DONE.
//  reti with SP=16'h0010, rdata 24'h001234 then 24'h000003
//   -> ret_addr_o=001234, ret_status_o=000003; sp_o=0012; ret_valid_o pulse.
//  push_i and load_i both set -> only push executes; a single mem beat is issued.
//  rst low mid-ACCESS -> mem_req_o=0 and stall_o=0 same cycle; sp_o=SP_INIT.
//   A stray mem_ack_i after reset changes nothing.

Source files
------------

// File: rtl/stage2_mem_ctrl.sv
// stage2_mem_ctrl
//   Stage-2 memory/stack sequencer. Accepts one load/store/push/pop/reti
//   from the stage-1/2 pipeline register, runs the req/ack data-memory
//   beats for it, owns the stack pointer (full-descending), and stalls the
//   upstream register while a transaction is outstanding.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   valid_i               stage-2 holds a live instruction
//   load_i .. reti_i      op flags (priority reti > pop > push > load > store)
//   addr_base_i, imm_i    address base and signed 9-bit offset
//   data_i                store/push write data
//   stall_o               hold stage-1/2 register
//   mem_req_o/we/addr/wdata, mem_ack_i, mem_rdata_i   memory handshake
//   rdata_o, rdata_valid_o                load/pop result and pulse
//   ret_addr_o, ret_status_o, ret_valid_o reti results and pulse
//   sp_o                  current stack pointer
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for valid_i & memop; launches the first beat
// ACCESS | first (or only) beat outstanding, waiting for mem_ack_i
// RETI2  | second reti beat (status word) outstanding
// DONE   | one-cycle completion; result pulses high, stall released
module stage2_mem_ctrl #(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              reti_i,
  input  logic [23:0]       addr_base_i,
  input  logic [23:0]       data_i,
  input  logic [8:0]        imm_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [23:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [23:0]       mem_rdata_i,
  output logic [23:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic [23:0]       ret_addr_o,
  output logic [23:0]       ret_status_o,
  output logic              ret_valid_o,
  output logic [ADDR_W-1:0] sp_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RETI2, S_DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_LOAD, OP_STORE, OP_PUSH, OP_POP, OP_RETI} op_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  op_t               op_sel, op_q;
  logic              start;
  logic [ADDR_W-1:0] sp_q, sp_inc, sp_dec;
  logic [23:0]       ea_full;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       wdata_q, rdata_q, ret_addr_q, ret_status_q;

  always_comb begin
    op_sel = OP_NONE;
    if (reti_i)       op_sel = OP_RETI;
    else if (pop_i)   op_sel = OP_POP;
    else if (push_i)  op_sel = OP_PUSH;
    else if (load_i)  op_sel = OP_LOAD;
    else if (store_i) op_sel = OP_STORE;
  end

  assign start = valid_i && (op_sel != OP_NONE);

  // Effective address is formed at full operand width and then truncated.
  assign ea_full = addr_base_i + {{15{imm_i[8]}}, imm_i};
  assign ea      = ea_full[ADDR_W-1:0];

  if (ADDR_W < 24) begin : g_ea_hi
    logic unused_ea_hi;
    assign unused_ea_hi = ^ea_full[23:ADDR_W];
  end

  assign sp_inc = sp_q + ONE;
  assign sp_dec = sp_q - ONE;

  // First-beat address/direction for the winning op.
  always_comb begin
    acc_addr = ea;
    acc_we   = 1'b0;
    case (op_sel)
      OP_PUSH:          begin acc_addr = sp_dec; acc_we = 1'b1; end
      OP_POP, OP_RETI:  begin acc_addr = sp_q;   acc_we = 1'b0; end
      OP_STORE:         begin acc_addr = ea;     acc_we = 1'b1; end
      default:          begin acc_addr = ea;     acc_we = 1'b0; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCESS;
      S_ACCESS: if (mem_ack_i) state_d = (op_q == OP_RETI) ? S_RETI2 : S_DONE;
      S_RETI2:  if (mem_ack_i) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: request, stack pointer and captured read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q         <= OP_NONE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sp_q         <= SP_INIT;
      rdata_q      <= '0;
      ret_addr_q   <= '0;
      ret_status_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_sel;
            req_q   <= 1'b1;
            we_q    <= acc_we;
            addr_q  <= acc_addr;
            wdata_q <= data_i;
          end
        end
        S_ACCESS: begin
          if (mem_ack_i) begin
            case (op_q)
              OP_PUSH: sp_q <= sp_dec;
              OP_POP: begin
                sp_q    <= sp_inc;
                rdata_q <= mem_rdata_i;
              end
              OP_LOAD: rdata_q <= mem_rdata_i;
              OP_RETI: begin
                sp_q       <= sp_inc;
                ret_addr_q <= mem_rdata_i;
                addr_q     <= sp_inc;
              end
              default: ;
            endcase
            // reti keeps req high and moves straight on to its status beat
            if (op_q != OP_RETI) req_q <= 1'b0;
          end
        end
        S_RETI2: begin
          if (mem_ack_i) begin
            sp_q         <= sp_inc;
            ret_status_q <= mem_rdata_i;
            req_q        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic. stall_o is gated by rst so it drops with the reset.
  always_comb begin
    stall_o       = rst && (((state_q == S_IDLE) && start) ||
                            (state_q == S_ACCESS) || (state_q == S_RETI2));
    rdata_valid_o = (state_q == S_DONE) && ((op_q == OP_LOAD) || (op_q == OP_POP));
    ret_valid_o   = (state_q == S_DONE) && (op_q == OP_RETI);
  end

  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign rdata_o      = rdata_q;
  assign ret_addr_o   = ret_addr_q;
  assign ret_status_o = ret_status_q;
  assign sp_o         = sp_q;

endmodule
